seq_divider_4bit: RTL and testbench
===================================

SEQ_DIVIDER_4BIT -- requirements
Module: seq_divider_4bit

Interface
REQ-001 SHALL have parameter W, default 4, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request a division, sampled on clk rise.
REQ-005 SHALL have port dividend  input  W  numerator, captured when start is accepted.
REQ-006 SHALL have port divisor  input  W  denominator, captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high while a division is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when results become valid.
REQ-009 SHALL have port quotient  output  W  unsigned floor(dividend/divisor).
REQ-010 SHALL have port remainder  output  W  unsigned dividend mod divisor.
REQ-011 SHALL have port div0  output  1  divide-by-zero flag; present only with DIV0_ERR_EN.

Function
REQ-012 SHALL perform unsigned restoring division, one quotient bit per cycle, MSB first.
REQ-013 SHALL implement states IDLE, RUN, DONE.
- IDLE->RUN on start=1.
- RUN->DONE after exactly W iterations.
- DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL accept start only in IDLE; start in RUN or DONE is ignored and operands are not recaptured.
REQ-015 SHALL hold busy=1 in RUN and DONE, and busy=0 in IDLE.
REQ-016 SHALL assert done for exactly the DONE cycle, W+1 clocks after the accepting edge.
REQ-017 SHALL update quotient and remainder only on entry to DONE, then hold them until the next DONE.
REQ-018 SHALL use a W+1-bit partial remainder for each trial subtract; if the difference is non-negative, the quotient bit is 1 and the difference is kept, otherwise the quotient bit is 0 and the prior value is restored.
REQ-019 SHALL, when divisor=0 and DIV0_ERR_EN is absent, run the normal W cycles and produce quotient = all ones, remainder = dividend.
REQ-020 SHALL accept a start asserted in the cycle immediately after DONE (IDLE), i.e. back-to-back operations with no gap.

Reset
REQ-021 SHALL, on rst_n=0, immediately force state IDLE, busy=0, done=0, quotient=0, remainder=0, and div0=0 if present.
REQ-022 SHALL, on reset mid-RUN, abandon the operation, produce no done pulse, and accept a new start once rst_n=1.

Configuration
REQ-023 SHALL use the macro DIV0_ERR_EN to control divide-by-zero handling.
REQ-024 SHALL, with DIV0_ERR_EN defined, go IDLE->DONE directly when the accepted divisor is 0, with the following results:
- done one cycle after the accepting edge;
- div0=1;
- quotient = all ones, remainder = dividend.
REQ-025 SHALL, with DIV0_ERR_EN defined, set div0=0 on every non-zero-divisor completion and hold div0 alongside the results.
REQ-026 SHALL, without DIV0_ERR_EN, omit the div0 port and follow REQ-019.

Structure
REQ-027 SHALL take the state enum typedef and the default width constant from shared package div_pkg.
REQ-028 SHALL instantiate one combinational sub-module, div_step, which computes the trial subtract, the quotient bit and the next partial remainder.
REQ-029 SHALL contain exactly one iteration counter of width clog2(W)+1.

Verification
REQ-030 SHALL cover: 13/4 -> done at start+5 cycles, quotient=3, remainder=1.
REQ-031 SHALL cover: 15/1 -> quotient=15, remainder=0; and 0/7 -> quotient=0, remainder=0.
REQ-032 SHALL cover: 9/0 -> with DIV0_ERR_EN, done at start+1, div0=1, quotient=15, remainder=9; without it, done at start+5 with the same quotient and remainder.
REQ-033 SHALL cover: start=1 held during RUN with new operands -> first result unchanged, no second capture until IDLE.
REQ-034 SHALL cover: rst_n pulsed low at RUN cycle 2 -> outputs zero, no done pulse; then 6/3 -> quotient=2, remainder=0.
REQ-035 SHALL cover: exhaustive sweep of all 256 operand pairs, including back-to-back starts -> every result matches the reference model.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

    localparam int DIV_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W:0]   rem_in,
    input  logic [W-1:0] quo_in,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_out,
    output logic [W-1:0] quo_out
);

    logic [W+1:0] shifted;
    logic [W+1:0] diff;
    logic         neg;

    // NOTE: purely combinational, so blocking assignments; every output is written on every path.
    always_comb begin
        shifted = {rem_in, quo_in[W-1]};
        diff    = shifted - {2'b00, divisor};
        neg     = diff[W+1];
        rem_out = neg ? shifted[W:0] : diff[W:0];
        quo_out = {quo_in[W-2:0], ~neg};
    end

endmodule

// File: rtl/seq_divider_4bit.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// Define DIV0_ERR_EN to add the div0 port and a one-cycle divide-by-zero fast path.
module seq_divider_4bit
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
`ifdef DIV0_ERR_EN
    ,
    output logic         div0
`endif
);

    localparam int CW = $clog2(W) + 1;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W:0]     rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [W-1:0]   quotient_q, quotient_d;
    logic [W-1:0]   remainder_q, remainder_d;
`ifdef DIV0_ERR_EN
    logic           div0_q, div0_d;
`endif

    logic [W:0]     step_rem;
    logic [W-1:0]   step_quo;

    div_step #(.W(W)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef DIV0_ERR_EN
        div0_d      = div0_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = '0;
                    quo_d   = dividend;
                    dvs_d   = divisor;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef DIV0_ERR_EN
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        div0_d      = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CW'(1);
                // Results are published only on the transition into DONE.
                if (cnt_q == CW'(W - 1)) begin
                    state_d     = DONE;
                    quotient_d  = step_quo;
                    remainder_d = step_rem[W-1:0];
`ifdef DIV0_ERR_EN
                    div0_d      = 1'b0;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV0_ERR_EN
            div0_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
`ifdef DIV0_ERR_EN
            div0_q      <= div0_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
`ifdef DIV0_ERR_EN
    assign div0      = div0_q;
`endif

endmodule

// File: tb/tb_seq_divider_4bit.sv
// Randomized self-checking bench for seq_divider_4bit; adapts to DIV0_ERR_EN.
module tb_seq_divider_4bit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done;
    logic [W-1:0] quotient, remainder;
    logic         div0_obs;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_divider_4bit #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV0_ERR_EN
        ,
        .div0      (div0_obs)
`endif
    );

`ifndef DIV0_ERR_EN
    assign div0_obs = 1'b0;
`endif

`ifdef DIV0_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // Reference model straight from the arithmetic definition.
    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r, output int lat, output int d0);
        if (b == 0) begin
            q   = (1 << W) - 1;
            r   = a;
            lat = ERR_EN ? 1 : W + 1;
            d0  = ERR_EN ? 1 : 0;
        end else begin
            q   = a / b;
            r   = a % b;
            lat = W + 1;
            d0  = 0;
        end
    endfunction

    // Issue one division from IDLE; latency counts negedges after the accepting edge until done.
    task automatic run_div(input int a, input int b, output int q, output int r,
                           output int lat, output int d0);
        @(negedge clk);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        q  = int'(quotient);
        r  = int'(remainder);
        d0 = int'(div0_obs);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, quotient, remainder, div0_obs} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d div0=%b, want all 0",
                     busy, done, quotient, remainder, div0_obs);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        int cases[5][2] = '{'{13, 4}, '{15, 1}, '{0, 7}, '{9, 0}, '{6, 3}};
        int q, r, lat, d0, eq, er, el, ed;
        foreach (cases[i]) begin
            ref_div(cases[i][0], cases[i][1], eq, er, el, ed);
            run_div(cases[i][0], cases[i][1], q, r, lat, d0);
            n_cmp++;
            if (q !== eq || r !== er || lat !== el || d0 !== ed) begin
                n_err++;
                $display("FAIL directed %0d/%0d: got q=%0d r=%0d lat=%0d div0=%0d, want q=%0d r=%0d lat=%0d div0=%0d",
                         cases[i][0], cases[i][1], q, r, lat, d0, eq, er, el, ed);
            end
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL directed_busy_in_done: got %b want 1", busy);
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL directed_done_pulse: got done=%b busy=%b want 0 0", done, busy);
            end
            n_cmp++;
            if (int'(quotient) !== eq || int'(remainder) !== er) begin
                n_err++;
                $display("FAIL directed_hold: got q=%0d r=%0d want q=%0d r=%0d", quotient, remainder, eq, er);
            end
        end
    endtask

    task automatic test_start_ignored;
        int lat = 0;
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        @(posedge clk);
        @(negedge clk);
        dividend = 4'd2; divisor = 4'd1;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (quotient !== 4'd3 || remainder !== 4'd1 || lat !== W + 1) begin
            n_err++;
            $display("FAIL start_ignored_first: got q=%0d r=%0d lat=%0d want q=3 r=1 lat=%0d",
                     quotient, remainder, lat, W + 1);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_ignored_idle: got busy=%b want 0", busy);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (quotient !== 4'd2 || remainder !== 4'd0 || lat !== W + 1) begin
            n_err++;
            $display("FAIL start_ignored_second: got q=%0d r=%0d lat=%0d want q=2 r=0 lat=%0d",
                     quotient, remainder, lat, W + 1);
        end
    endtask

    task automatic test_reset_mid_run;
        int seen_done = 0;
        int q, r, lat, d0;
        @(negedge clk);
        start = 1'b1; dividend = 4'd14; divisor = 4'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, quotient, remainder, div0_obs} !== '0) begin
            n_err++;
            $display("FAIL mid_run_reset_outputs: got busy=%b done=%b q=%0d r=%0d div0=%b want all 0",
                     busy, done, quotient, remainder, div0_obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        n_cmp++;
        if (seen_done !== 0) begin
            n_err++;
            $display("FAIL mid_run_no_done: got %0d done cycles want 0", seen_done);
        end
        run_div(6, 3, q, r, lat, d0);
        n_cmp++;
        if (q !== 2 || r !== 0 || lat !== W + 1) begin
            n_err++;
            $display("FAIL after_reset_6_3: got q=%0d r=%0d lat=%0d want q=2 r=0 lat=%0d", q, r, lat, W + 1);
        end
    endtask

    // All 256 pairs in a random permutation; mostly back-to-back, occasionally with idle gaps.
    task automatic test_sweep_back_to_back;
        int stride = int'($urandom_range(0, 127)) * 2 + 1;
        int offset = int'($urandom_range(0, 255));
        int q, r, lat, d0, eq, er, el, ed;
        for (int i = 0; i < 256; i++) begin
            int idx = (i * stride + offset) % 256;
            int a = idx / 16;
            int b = idx % 16;
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            ref_div(a, b, eq, er, el, ed);
            run_div(a, b, q, r, lat, d0);
            n_cmp++;
            if (q !== eq || r !== er || lat !== el || d0 !== ed) begin
                n_err++;
                $display("FAIL sweep %0d/%0d: got q=%0d r=%0d lat=%0d div0=%0d, want q=%0d r=%0d lat=%0d div0=%0d",
                         a, b, q, r, lat, d0, eq, er, el, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_mid_run();
        test_sweep_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
